// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: data-memory request/response bus between the LSU and memory
interface mem_stage_lsu_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [3:0]  mem_req_wstrb;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wstrb, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wstrb, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit with lane alignment, load extension and timeout
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          alu_out,
  input  logic [31:0]          rs2_data,
  input  logic [3:0]           dm_w_en,
  input  logic                 wb_sel,
  input  logic                 wb_en,
  input  logic [2:0]           func3,
  mem_stage_lsu_if.master      mem,
  output logic                 stall,
  output logic [31:0]          ld_data,
  output logic                 ld_valid,
  output logic                 misaligned_exc,
  output logic                 bus_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t      state_q, state_d;
  logic        we_q, we_d, ldv_q, ldv_d, mis_q, mis_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ld_data_q, ld_data_d, cnt_q, cnt_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f_q, f_d;
  logic        is_st, is_ld, acc, is_b, is_h, mis_a, to_hit;
  logic [3:0]  st_strb;
  logic [31:0] st_data, sh, ext;
  logic [15:0] half;
  assign is_st   = |dm_w_en;
  assign is_ld   = wb_sel & wb_en & ~is_st;
  assign acc     = is_st | is_ld;
  // reserved widths (011, 11x) fall through to word handling
  assign is_b    = func3[1:0] == 2'b00;
  assign is_h    = func3[1:0] == 2'b01;
  assign mis_a   = is_h ? alu_out[0] : (!is_b && |alu_out[1:0]);
  assign st_strb = is_b ? 4'b0001 << alu_out[1:0] : is_h ? 4'b0011 << {alu_out[1], 1'b0} : 4'b1111;
  assign st_data = is_b ? {4{rs2_data[7:0]}} : is_h ? {2{rs2_data[15:0]}} : rs2_data;
  assign sh      = mem.mem_rsp_rdata >> {off_q, 3'b000};
  assign half    = off_q[1] ? mem.mem_rsp_rdata[31:16] : mem.mem_rsp_rdata[15:0];
  assign ext     = f_q[1:0] == 2'b00 ? {{24{~f_q[2] & sh[7]}}, sh[7:0]} :
                   f_q[1:0] == 2'b01 ? {{16{~f_q[2] & half[15]}}, half} : mem.mem_rsp_rdata;
  assign to_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q + 32'd1 >= TIMEOUT_CYCLES);
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    off_d     = off_q;
    f_d       = f_q;
    cnt_d     = cnt_q;
    ld_data_d = ld_data_q;
    ldv_d     = ldv_q;
    mis_d     = mis_q;
    err_d     = err_q;
    stall     = 1'b0;
    case (state_q)
      IDLE: begin
        ldv_d = 1'b0;
        mis_d = 1'b0;
        err_d = 1'b0;
        cnt_d = '0;
        stall = acc;
        if (acc && mis_a) begin
          mis_d   = 1'b1;
          state_d = DONE;
        end else if (acc) begin
          we_d    = is_st;
          addr_d  = {alu_out[31:2], 2'b00};
          wstrb_d = is_st ? st_strb : 4'b0000;
          wdata_d = is_st ? st_data : 32'h0;
          off_d   = alu_out[1:0];
          f_d     = func3;
          state_d = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        cnt_d = cnt_q + 32'd1;
        if (mem.mem_req_ready) state_d = we_q ? DONE : WAIT;
        else if (to_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q + 32'd1;
        if (mem.mem_rsp_valid) begin
          ld_data_d = ext;
          ldv_d     = 1'b1;
          state_d   = DONE;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      off_q     <= '0;
      f_q       <= '0;
      cnt_q     <= '0;
      ld_data_q <= '0;
      ldv_q     <= 1'b0;
      mis_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      off_q     <= off_d;
      f_q       <= f_d;
      cnt_q     <= cnt_d;
      ld_data_q <= ld_data_d;
      ldv_q     <= ldv_d;
      mis_q     <= mis_d;
      err_q     <= err_d;
    end
  end
  assign mem.mem_req_valid = state_q == REQ;
  assign mem.mem_req_we    = we_q;
  assign mem.mem_req_addr  = addr_q;
  assign mem.mem_req_wstrb = wstrb_q;
  assign mem.mem_req_wdata = wdata_q;
  assign ld_data           = ld_data_q;
  assign ld_valid          = state_q == DONE && ldv_q;
  assign misaligned_exc    = state_q == DONE && mis_q;
  assign bus_err           = state_q == DONE && err_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed scoreboard bench for the memory-stage LSU
module tb_mem_stage_lsu;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] alu_out = '0, rs2_data = '0;
  logic [3:0]  dm_w_en = '0;
  logic        wb_sel = 1'b0, wb_en = 1'b0;
  logic [2:0]  func3 = '0;
  logic        stall, ld_valid, misaligned_exc, bus_err;
  logic [31:0] ld_data;
  int          n_tests = 0, n_fail = 0;
  typedef struct packed {logic we; logic [31:0] addr; logic [3:0] wstrb; logic [31:0] wdata;} req_t;
  req_t        req_q[$];
  logic [31:0] ld_q[$];
  always #5 clk = ~clk;
  mem_stage_lsu_if bus();
  mem_stage_lsu #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .alu_out(alu_out), .rs2_data(rs2_data), .dm_w_en(dm_w_en),
    .wb_sel(wb_sel), .wb_en(wb_en), .func3(func3), .mem(bus), .stall(stall),
    .ld_data(ld_data), .ld_valid(ld_valid), .misaligned_exc(misaligned_exc), .bus_err(bus_err)
  );
  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, bus.mem_req_valid, 1'b0);
    chk({tag, "_we"}, bus.mem_req_we, 1'b0);
    chk({tag, "_addr"}, bus.mem_req_addr, 32'h0);
    chk({tag, "_wstrb"}, bus.mem_req_wstrb, 4'h0);
    chk({tag, "_wdata"}, bus.mem_req_wdata, 32'h0);
    chk({tag, "_lddata"}, ld_data, 32'h0);
    chk({tag, "_ldvalid"}, ld_valid, 1'b0);
    chk({tag, "_mis"}, misaligned_exc, 1'b0);
    chk({tag, "_err"}, bus_err, 1'b0);
    chk({tag, "_stall"}, stall, 1'b0);
  endtask
  // Called at a falling edge; drives one instruction and plays the memory side until DONE.
  task automatic access(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] wen, input logic ld, input logic [2:0] f3,
                        input int rdy_dly, input int rsp_dly, input logic [31:0] rdata,
                        input logic exp_hs, input logic exp_mis, input logic exp_err, input int exp_stall,
                        input logic [31:0] e_addr, input logic [3:0] e_strb, input logic [31:0] e_wdata,
                        input logic [31:0] e_ld);
    int   stalls = 0, vcnt = 0, wcnt = 0;
    logic hs = 1'b0, done = 1'b0;
    req_t cur, first, exp_r;
    if (exp_hs) req_q.push_back({wen != 4'h0, e_addr, e_strb, e_wdata});
    if (ld && !exp_mis && !exp_err) ld_q.push_back(e_ld);
    alu_out = a; rs2_data = d; dm_w_en = wen; wb_sel = ld; wb_en = ld; func3 = f3;
    bus.mem_req_ready = rdy_dly == 0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = rdata;
    #1;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      if (c > 0 && !stall) begin
        done = 1'b1;
        chk({tag, "_stalls"}, stalls, exp_stall);
        chk({tag, "_mis"}, misaligned_exc, exp_mis);
        chk({tag, "_err"}, bus_err, exp_err);
        chk({tag, "_ldvalid"}, ld_valid, ld && !exp_mis && !exp_err);
        chk({tag, "_hs"}, hs, exp_hs);
        if (ld_valid && ld_q.size() == 0) chk({tag, "_ld_unexpected"}, 1'b1, 1'b0);
        else if (ld_valid) chk({tag, "_lddata"}, ld_data, ld_q.pop_front());
        dm_w_en = '0; wb_sel = 1'b0; wb_en = 1'b0;
        @(negedge clk);
        chk({tag, "_pulse_end"}, {ld_valid, misaligned_exc, bus_err, stall, bus.mem_req_valid}, 5'b0);
      end else begin
        if (stall) stalls++;
        if (bus.mem_req_valid) begin
          cur = {bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wstrb, bus.mem_req_wdata};
          if (vcnt == 0) first = cur;
          else chk({tag, "_stable"}, cur, first);
          bus.mem_req_ready = vcnt >= rdy_dly;
          vcnt++;
          if (bus.mem_req_ready) begin
            hs = 1'b1;
            if (req_q.size() == 0) chk({tag, "_req_unexpected"}, 1'b1, 1'b0);
            else begin
              exp_r = req_q.pop_front();
              chk({tag, "_we"}, cur.we, exp_r.we);
              chk({tag, "_addr"}, cur.addr, exp_r.addr);
              if (exp_r.we) chk({tag, "_wstrb"}, cur.wstrb, exp_r.wstrb);
              if (exp_r.we) chk({tag, "_wdata"}, cur.wdata, exp_r.wdata);
            end
          end
        end else if (hs && ld) begin
          bus.mem_rsp_valid = wcnt == rsp_dly;
          wcnt++;
        end
      end
    end
    if (!done) chk({tag, "_no_done"}, 1'b0, 1'b1);
  endtask
  initial begin
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = '0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    //   tag      addr         rs2          wen    ld f3      rdy rsp rdata        hs mis err stl e_addr       strb     wdata        ld_exp
    access("sb",  32'h1003, 32'hAABBCC5A, 4'b0001, 0, 3'b000, 0, 0, 32'h0,        1, 0, 0, 2, 32'h1000, 4'b1000, 32'h5A5A5A5A, 32'h0);
    access("lb",  32'h2001, 32'h0,        4'b0000, 1, 3'b000, 0, 2, 32'h0000F300, 1, 0, 0, 5, 32'h2000, 4'b0000, 32'h0,        32'hFFFFFFF3);
    access("lbu", 32'h2001, 32'h0,        4'b0000, 1, 3'b100, 0, 2, 32'h0000F300, 1, 0, 0, 5, 32'h2000, 4'b0000, 32'h0,        32'h000000F3);
    access("lh",  32'h2002, 32'h0,        4'b0000, 1, 3'b001, 0, 0, 32'h80011234, 1, 0, 0, 3, 32'h2000, 4'b0000, 32'h0,        32'hFFFF8001);
    access("lhu", 32'h2000, 32'h0,        4'b0000, 1, 3'b101, 0, 1, 32'h1234F00D, 1, 0, 0, 4, 32'h2000, 4'b0000, 32'h0,        32'h0000F00D);
    access("lb3", 32'h2003, 32'h0,        4'b0000, 1, 3'b000, 0, 0, 32'h7F000000, 1, 0, 0, 3, 32'h2000, 4'b0000, 32'h0,        32'h0000007F);
    access("lwm", 32'h2005, 32'h0,        4'b0000, 1, 3'b010, 0, 0, 32'h0,        0, 1, 0, 1, 32'h0,    4'b0000, 32'h0,        32'h0);
    access("sw4", 32'h3008, 32'h12345678, 4'b1111, 0, 3'b010, 4, 0, 32'h0,        1, 0, 0, 6, 32'h3008, 4'b1111, 32'h12345678, 32'h0);
    access("sh",  32'h3006, 32'hDEADBEEF, 4'b0011, 0, 3'b001, 0, 0, 32'h0,        1, 0, 0, 2, 32'h3004, 4'b1100, 32'hBEEFBEEF, 32'h0);
    access("shm", 32'h3001, 32'hDEADBEEF, 4'b0011, 0, 3'b001, 0, 0, 32'h0,        0, 1, 0, 1, 32'h0,    4'b0000, 32'h0,        32'h0);
    access("r3m", 32'h3002, 32'h11223344, 4'b1111, 0, 3'b011, 0, 0, 32'h0,        0, 1, 0, 1, 32'h0,    4'b0000, 32'h0,        32'h0);
    access("r6",  32'h3004, 32'h11223344, 4'b1111, 0, 3'b110, 0, 0, 32'h0,        1, 0, 0, 2, 32'h3004, 4'b1111, 32'h11223344, 32'h0);
    access("tow", 32'h4000, 32'h0,        4'b0000, 1, 3'b010, 0, -1, 32'h0,       1, 0, 1, 9, 32'h4000, 4'b0000, 32'h0,        32'h0);
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stray", {ld_valid, stall, bus.mem_req_valid, bus_err}, 4'b0);
    end
    bus.mem_rsp_valid = 1'b0;
    access("tor", 32'h4004, 32'h0,        4'b0000, 1, 3'b010, 100, 0, 32'h0,      0, 0, 1, 9, 32'h0,    4'b0000, 32'h0,        32'h0);
    alu_out = 32'h5000; wb_sel = 1'b1; wb_en = 1'b1; func3 = 3'b010; bus.mem_req_ready = 1'b1;
    @(negedge clk);
    chk("rst_req", {bus.mem_req_valid, stall}, 2'b11);
    @(negedge clk);
    chk("rst_wait", {bus.mem_req_valid, stall}, 2'b01);
    rst = 1'b1; wb_sel = 1'b0; wb_en = 1'b0; alu_out = '0; bus.mem_rsp_valid = 1'b1;
    @(negedge clk);
    chk_idle_outputs("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stale", {ld_valid, stall, bus.mem_req_valid}, 3'b0);
    bus.mem_rsp_valid = 1'b0;
    access("lw0", 32'h0,    32'h0,        4'b0000, 1, 3'b010, 0, 0, 32'hCAFEF00D, 1, 0, 0, 3, 32'h0,    4'b0000, 32'h0,        32'hCAFEF00D);
    chk("sb_empty", req_q.size() + ld_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit. Consumes the execute/memory pipeline register outputs and performs the data-memory access over a valid/ready request and response interface.
- Aligns store data and byte strobes, sign- or zero-extends load data, and reports misaligned and timed-out accesses.
- Holds the pipeline with `stall` while an access is outstanding. The pipeline freezes E/M while `stall` is high.

Parameters:
- `TIMEOUT_CYCLES`, 255: maximum cycles in REQ+WAIT before bus error; 0 disables the timeout.

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `alu_out`  in  32  effective byte address
- `rs2_data`  in  32  store source data
- `dm_w_en`  in  4  nonzero = store instruction
- `wb_sel`  in  1  1 = writeback from memory (load)
- `wb_en`  in  1  register writeback enable
- `func3`  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `mem_req_valid`  out  1  request valid
- `mem_req_ready`  in  1  memory accepts request
- `mem_req_we`  out  1  1 = write
- `mem_req_addr`  out  32  word address (`alu_out` with bits [1:0] = 0)
- `mem_req_wstrb`  out  4  byte lane strobes
- `mem_req_wdata`  out  32  lane-replicated store data
- `mem_rsp_valid`  in  1  load response valid
- `mem_rsp_rdata`  in  32  load response word
- `stall`  out  1  hold pipeline
- `ld_data`  out  32  extended load result
- `ld_valid`  out  1  `ld_data` valid this cycle
- `misaligned_exc`  out  1  misaligned access pulse
- `bus_err`  out  1  timeout pulse

Behaviour:
- Access request: load = `wb_sel` & `wb_en` & (`dm_w_en` == 0); store = `dm_w_en` != 0; otherwise no access.
- States: IDLE, REQ, WAIT, DONE.
- Reset values: state IDLE; all outputs 0 (`mem_req_valid`, `mem_req_we`, `mem_req_addr`, `mem_req_wstrb`, `mem_req_wdata`, `ld_data`, `ld_valid`, `misaligned_exc`, `bus_err`, `stall`).
- Misalignment check (in IDLE):
  - H/HU with addr[0] = 1, or W with addr[1:0] != 0, is misaligned.
  - No request is issued; go to DONE with `misaligned_exc` = 1 in DONE.
- Issue (in IDLE with an aligned access):
  - Latch addr/strobe/data/func3 and load them into the request registers.
  - Go to REQ; counter cleared.
- `stall` is combinational: 1 when (IDLE and an access is present) or REQ or WAIT. It is 0 in DONE and on non-access cycles.
- REQ:
  - `mem_req_valid` = 1; request fields are stable until the handshake.
  - On `mem_req_valid` & `mem_req_ready`: store -> DONE; load -> WAIT.
- WAIT: on `mem_rsp_valid`, capture the response into `ld_data` (extended) and go to DONE.
- DONE:
  - Exactly one cycle; `ld_valid` = 1 for a completed load.
  - The pipeline advances this cycle. Next state is always IDLE, so the same instruction is never re-issued.
- Access latency: minimum 2 cycles stalled for a store with `mem_req_ready` = 1 (IDLE, REQ), then DONE. A load with zero-wait response takes IDLE, REQ, WAIT, then DONE.
- Store lanes, with a = addr[1:0]:
  - B: wstrb = 0001 << a; wdata = {4{rs2[7:0]}}.
  - H: wstrb = 0011 << (2·a[1]); wdata = {2{rs2[15:0]}}.
  - W: wstrb = 1111; wdata = rs2.
- Load extraction: byte lane a, or halfword lane a[1]. B/H sign-extend, BU/HU zero-extend, W passes the word through.
- Timeout: counter increments in REQ and WAIT. When it reaches `TIMEOUT_CYCLES` (nonzero), drop valid, go to DONE with `bus_err` = 1, and leave `ld_valid` = 0.
- Boundary and corner cases:
  - `mem_rsp_valid` outside WAIT is ignored, including stale responses after reset or timeout.
  - Reset mid-access: `mem_req_valid` is 0 the cycle after reset; no partial state survives.
  - `mem_req_ready` asserted in the same cycle as entry into REQ is honoured immediately.
  - Reserved func3 values (011, 11x) are treated as W for both the strobe and the alignment check.
  - `misaligned_exc` and `bus_err` are never both 1.

Test Plan:
1. SB: `alu_out` = 0x1003, `rs2_data` = 0xAABBCC5A, `dm_w_en` = 0001, ready tied to 1 -> one request with addr 0x1000, wstrb 1000, wdata 0x5A5A5A5A, we = 1. `stall` is high 2 cycles, then DONE.
2. LB at 0x2001 with rdata 0x0000F300, response 3 cycles after accept -> `ld_data` 0xFFFFFFF3 and `ld_valid` for exactly 1 cycle; `stall` is held throughout WAIT. LBU with the same stimulus -> 0x000000F3.
3. LH at 0x2002, rdata 0x8001xxxx -> 0xFFFF8001. LW at 0x2005 -> `misaligned_exc` pulse, no `mem_req_valid`, 1 stall cycle.
4. `mem_req_ready` low 4 cycles -> valid, addr, wstrb and wdata are held stable all 4 cycles; the handshake completes on the 5th.
5. `TIMEOUT_CYCLES` = 8, load with no response -> `bus_err` pulse after 8 cycles, `ld_valid` 0. A later stray `mem_rsp_valid` is ignored.
6. `rst` asserted during WAIT -> next cycle all outputs 0 and state IDLE. A following LW at 0x0 completes normally.
